// File: rtl/lcg_stim_gen_if.sv
// Vector delivery bus between the LCG stimulus source and its consumer.
// Handshake: a vector moves on a rising edge where vec_valid && vec_ready;
// while vec_valid is high and vec_ready is low, vec_data and vec_valid hold.
interface lcg_stim_gen_if #(
   parameter int OUT_W = 135
);
   logic             vec_valid;
   logic             vec_ready;
   logic [OUT_W-1:0] vec_data;

   modport master (
      output vec_valid,
      output vec_data,
      input  vec_ready
   );

   modport slave (
      input  vec_valid,
      input  vec_data,
      output vec_ready
   );
endinterface

// File: rtl/lcg_stim_gen.sv
// LCG stimulus source: builds OUT_W-bit vectors from consecutive 32-bit LCG
// words (LSB word first) with one shared multiplier, one word per cycle, and
// presents each vector over a valid/ready handshake.
module lcg_stim_gen #(
   parameter int          OUT_W = 135,
   parameter logic [31:0] SEED  = 32'd4105558988
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_load,
   input  logic [31:0] seed_in,
   input  logic        start,
   input  logic [31:0] num_vectors,
   lcg_stim_gen_if.master vec_if,
   output logic        busy,
   output logic        done,
   output logic [31:0] vec_count,
   output logic [1:0]  dbg_state
);

   localparam int          WORDS = (OUT_W + 31) / 32;
   localparam int          ASM_W = WORDS * 32;
   localparam int          KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] MULT  = 32'h41C6_4E6D;
   localparam logic [31:0] INC   = 32'h0000_3039;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GEN     = 2'd1,
      S_PRESENT = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e           state_q,     state_d;
   logic [31:0]      lcg_q,       lcg_d;
   logic [KW-1:0]    k_q,         k_d;
   logic [ASM_W-1:0] asm_q,       asm_d;
   logic [OUT_W-1:0] vec_data_q,  vec_data_d;
   logic             vec_valid_q, vec_valid_d;
   logic [31:0]      count_q,     count_d;
   logic [31:0]      num_q,       num_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;

   logic [31:0]      lcg_next;
   logic             more_left;

   // The single multiplier; only consumed while generating words.
   assign lcg_next = lcg_q * MULT + INC;

   // True when the vector being transferred is not the last of the run.
   assign more_left = ({1'b0, count_q} + 33'd1) < {1'b0, num_q};

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      lcg_d       = lcg_q;
      k_d         = k_q;
      asm_d       = asm_q;
      vec_data_d  = vec_data_q;
      vec_valid_d = vec_valid_q;
      count_d     = count_q;
      num_d       = num_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // Seed first, so a simultaneous start runs from the new seed.
            if (seed_load) lcg_d = seed_in;
            if (start) begin
               num_d   = num_vectors;
               count_d = '0;
               k_d     = '0;
               state_d = (num_vectors == 32'd0) ? S_DONE : S_GEN;
            end
         end
         S_GEN: begin
            lcg_d = lcg_next;
            for (int w = 0; w < WORDS; w++) begin
               if (k_q == KW'(w)) asm_d[32*w +: 32] = lcg_next;
            end
            if (k_q == KW'(WORDS - 1)) begin
               // Upper bits of the last word fall off in the truncation.
               vec_data_d  = asm_d[OUT_W-1:0];
               vec_valid_d = 1'b1;
               state_d     = S_PRESENT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_PRESENT: begin
            if (vec_valid_q && vec_if.vec_ready) begin
               count_d     = count_q + 32'd1;
               vec_valid_d = 1'b0;
               k_d         = '0;
               state_d     = more_left ? S_GEN : S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_GEN) || (state_d == S_PRESENT);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset discards any partial vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lcg_q       <= SEED;
         k_q         <= '0;
         asm_q       <= '0;
         vec_data_q  <= '0;
         vec_valid_q <= 1'b0;
         count_q     <= '0;
         num_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lcg_q       <= lcg_d;
         k_q         <= k_d;
         asm_q       <= asm_d;
         vec_data_q  <= vec_data_d;
         vec_valid_q <= vec_valid_d;
         count_q     <= count_d;
         num_q       <= num_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign vec_if.vec_valid = vec_valid_q;
   assign vec_if.vec_data  = vec_data_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign vec_count        = count_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed bench for lcg_stim_gen: hand-computed constants plus a small
// software LCG feeding an expected-vector queue.
module tb_lcg_stim_gen;

   localparam int          OUT_W = 135;
   localparam logic [31:0] SEED  = 32'd4105558988;
   localparam logic [31:0] A     = 32'h41C64E6D;
   localparam logic [31:0] C     = 32'h00003039;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_in;
   logic        start;
   logic [31:0] num_vectors;
   logic        busy;
   logic        done;
   logic [31:0] vec_count;
   logic [1:0]  dbg_state;

   lcg_stim_gen_if #(.OUT_W(OUT_W)) vif();

   always #5 clk = ~clk;

   lcg_stim_gen #(.OUT_W(OUT_W), .SEED(SEED)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seed_load   (seed_load),
      .seed_in     (seed_in),
      .start       (start),
      .num_vectors (num_vectors),
      .vec_if      (vif.master),
      .busy        (busy),
      .done        (done),
      .vec_count   (vec_count),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int               n_vec = 0;
   int               n_err = 0;
   logic [31:0]      m_state;
   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] exp_v;

   function automatic logic [31:0] lcg_step(input logic [31:0] s);
      return s * A + C;
   endfunction

   // Model one vector: five chained words, LSB word first, truncated.
   task automatic push_model_vec();
      logic [159:0] t;
      for (int w = 0; w < 5; w++) begin
         m_state = lcg_step(m_state);
         t[32*w +: 32] = m_state;
      end
      exp_q.push_back(t[OUT_W-1:0]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      seed_load   = 1'b0;
      seed_in     = '0;
      start       = 1'b0;
      num_vectors = '0;
      vif.vec_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      m_state = SEED;
   endtask

   task automatic start_run(input logic [31:0] n);
      start       = 1'b1;
      num_vectors = n;
      step();
      start = 1'b0;
   endtask

   // Steps until vec_valid is seen; cyc is the number of edges waited.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (vif.vec_valid !== 1'b1 && cyc < 50) begin
         step();
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      seed_load = 1'b0; seed_in = '0; start = 1'b0; num_vectors = '0;
      vif.vec_ready = 1'b0;
      #3;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_vec++; if (vif.vec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", vif.vec_valid); end
      n_vec++; if (vif.vec_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", vif.vec_data); end
      n_vec++; if (vec_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", vec_count); end
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      do_reset();
   endtask

   task automatic test_seed0();
      int cyc;
      seed_load = 1'b1; seed_in = 32'h0; step(); seed_load = 1'b0;
      m_state = 32'h0;
      vif.vec_ready = 1'b1;
      start_run(1);
      wait_valid(cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL seed0_latency: got %0d want 5", cyc); end
      n_vec++; if (vif.vec_data[31:0] !== 32'h00003039) begin n_err++; $display("FAIL seed0_word0: got %h want 00003039", vif.vec_data[31:0]); end
      n_vec++; if (vif.vec_data[63:32] !== 32'hD3DC167E) begin n_err++; $display("FAIL seed0_word1: got %h want d3dc167e", vif.vec_data[63:32]); end
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL seed0_vec: got %h want %h", vif.vec_data, exp_v); end
      step();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL seed0_done: got %b want 1", done); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL seed0_busy: got %b want 0", busy); end
      n_vec++; if (vif.vec_valid !== 1'b0) begin n_err++; $display("FAIL seed0_valid_drop: got %b want 0", vif.vec_valid); end
      n_vec++; if (vec_count !== 32'd1) begin n_err++; $display("FAIL seed0_count: got %0d want 1", vec_count); end
      seed_load = 1'b1; seed_in = 32'hDEADBEEF; step(); seed_load = 1'b0;
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL seed_in_done_stays: got %b want 1", done); end
   endtask

   task automatic test_four_vectors();
      int cyc;
      int gap;
      do_reset();
      vif.vec_ready = 1'b1;
      start_run(4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         wait_valid(cyc);
         gap = (i == 0) ? cyc : cyc + 1;
         n_vec++; if (gap != ((i == 0) ? 5 : 6)) begin n_err++; $display("FAIL four_gap%0d: got %0d want %0d", i, gap, (i == 0) ? 5 : 6); end
         push_model_vec(); exp_v = exp_q.pop_front();
         n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL four_vec%0d: got %h want %h", i, vif.vec_data, exp_v); end
      end
      step();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL four_done: got %b want 1", done); end
      n_vec++; if (vec_count !== 32'd4) begin n_err++; $display("FAIL four_count: got %0d want 4", vec_count); end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [OUT_W-1:0] snap;
      vif.vec_ready = 1'b0;
      start_run(2);
      wait_valid(cyc);
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL bp_vec0: got %h want %h", vif.vec_data, exp_v); end
      snap = exp_v;
      for (int i = 0; i < 10; i++) begin
         step();
         n_vec++;
         if (vif.vec_valid !== 1'b1 || vif.vec_data !== snap) begin
            n_err++; $display("FAIL bp_hold%0d: got valid %b data %h want valid 1 data %h", i, vif.vec_valid, vif.vec_data, snap);
         end
      end
      n_vec++; if (vec_count !== 32'd0) begin n_err++; $display("FAIL bp_count_held: got %0d want 0", vec_count); end
      vif.vec_ready = 1'b1;
      step();
      n_vec++; if (vec_count !== 32'd1) begin n_err++; $display("FAIL bp_count_release: got %0d want 1", vec_count); end
      wait_valid(cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL bp_latency: got %0d want 5", cyc); end
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL bp_vec1: got %h want %h", vif.vec_data, exp_v); end
      step();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", done); end
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL bp_data_kept: got %h want %h", vif.vec_data, exp_v); end
      n_vec++; if (vec_count !== 32'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", vec_count); end
   endtask

   task automatic test_zero_vectors();
      logic saw_valid;
      start_run(0);
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
      n_vec++; if (vec_count !== 32'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", vec_count); end
      saw_valid = vif.vec_valid;
      for (int i = 0; i < 5; i++) begin
         step();
         if (vif.vec_valid !== 1'b0) saw_valid = 1'b1;
      end
      n_vec++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid: got 1 want 0"); end
   endtask

   task automatic test_ignore_midrun();
      int cyc;
      vif.vec_ready = 1'b1;
      start_run(2);
      step();
      step();
      start = 1'b1; seed_load = 1'b1; seed_in = 32'h12345678; num_vectors = 32'd9;
      step();
      start = 1'b0; seed_load = 1'b0;
      wait_valid(cyc);
      n_vec++; if (cyc != 2) begin n_err++; $display("FAIL ign_latency: got %0d want 2", cyc); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b want 1", busy); end
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL ign_vec0: got %h want %h", vif.vec_data, exp_v); end
      start = 1'b1; seed_load = 1'b1;
      step();
      start = 1'b0; seed_load = 1'b0;
      n_vec++; if (vec_count !== 32'd1) begin n_err++; $display("FAIL ign_count1: got %0d want 1", vec_count); end
      wait_valid(cyc);
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL ign_vec1: got %h want %h", vif.vec_data, exp_v); end
      step();
      n_vec++; if (done !== 1'b1 || vec_count !== 32'd2) begin n_err++; $display("FAIL ign_end: got done %b count %0d want done 1 count 2", done, vec_count); end
      start_run(1);
      wait_valid(cyc);
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL continue_vec: got %h want %h", vif.vec_data, exp_v); end
      step();
   endtask

   task automatic test_seed_and_start();
      int cyc;
      seed_load = 1'b1; seed_in = 32'h0; start = 1'b1; num_vectors = 32'd1;
      step();
      seed_load = 1'b0; start = 1'b0;
      m_state = 32'h0;
      wait_valid(cyc);
      n_vec++; if (vif.vec_data[31:0] !== 32'h00003039) begin n_err++; $display("FAIL seedstart_word0: got %h want 00003039", vif.vec_data[31:0]); end
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL seedstart_vec: got %h want %h", vif.vec_data, exp_v); end
      step();
   endtask

   task automatic test_reset_midrun();
      int cyc;
      start_run(1);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: got busy %b done %b want 0 0", busy, done); end
      n_vec++; if (vif.vec_valid !== 1'b0 || vif.vec_data !== '0) begin n_err++; $display("FAIL rstmid_bus: got valid %b data %h want 0 0", vif.vec_valid, vif.vec_data); end
      n_vec++; if (vec_count !== 32'd0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL rstmid_state: got count %0d state %0d want 0 0", vec_count, dbg_state); end
      step();
      rst_n = 1'b1;
      m_state = SEED;
      vif.vec_ready = 1'b1;
      start_run(1);
      wait_valid(cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL rstmid_latency: got %0d want 5", cyc); end
      push_model_vec(); exp_v = exp_q.pop_front();
      n_vec++; if (vif.vec_data !== exp_v) begin n_err++; $display("FAIL rstmid_vec: got %h want %h", vif.vec_data, exp_v); end
      step();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_done: got %b want 1", done); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_seed0();
      test_four_vectors();
      test_backpressure();
      test_zero_vectors();
      test_ignore_midrun();
      test_seed_and_start();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run want finish before 200000ns");
      $fatal(1, "timeout");
   end

endmodule
